// File: rtl/pc_seq.sv
// pc_seq: fetch-stage program-counter sequencer.
// BOOT/RUN/TRAP control with stall, relative branch and absolute jump.
// A jump or branch whose target is misaligned sends the sequencer into TRAP
// instead of loading that target.
// Optional feature: define PC_SEQ_RETIRE_CNT_EN to add the 32-bit retire_cnt
// output, which counts the RUN cycles that advance without trapping.
module pc_seq #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h0000_0100),
    parameter int              INC        = 4,
    parameter int              ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,       // active-high async reset
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_offset,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            trap_clr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            trap,
    output logic [XLEN-1:0] trap_epc,
    output logic [1:0]      state
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]     retire_cnt
`endif
);

    // Low target bits that must be clear. A mask of zero (ALIGN_BITS == 0)
    // turns the alignment check off without needing a zero-width slice.
    localparam logic [XLEN-1:0] ALIGN_MASK =
        (ALIGN_BITS == 0) ? '0 : XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_TRAP = 2'b10,
        ST_BAD  = 2'b11
    } st_t;

    typedef struct packed {
        logic            req;
        logic [XLEN-1:0] target;
    } redir_t;

    st_t             st_q, st_d;
    redir_t          redir;
    logic            misalign;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_d;
    logic            retire_ok;

    // Sequential successor. It wraps modulo 2^XLEN and is never alignment checked.
    assign pc_next = pc + INC_V;
    assign state   = st_q;

    // Redirect target: jmp beats br_taken, and the branch sum wraps modulo 2^XLEN.
    always_comb begin
        redir.req    = jmp | br_taken;
        redir.target = jmp ? jmp_target : (pc + br_offset);
        misalign     = redir.req && ((redir.target & ALIGN_MASK) != '0);
    end

    // Next-state, next-pc and status outputs.
    always_comb begin
        st_d      = st_q;
        pc_d      = pc;
        epc_d     = trap_epc;
        retire_ok = 1'b0;
        pc_valid  = 1'b0;
        trap      = 1'b0;
        case (st_q)
            ST_BOOT: begin
                // pc holds the reset vector for one cycle; requests are ignored.
                st_d = ST_RUN;
            end
            ST_RUN: begin
                pc_valid = 1'b1;
                // A stall also drops any jmp or branch; the requester must hold it.
                if (!stall) begin
                    if (misalign) begin
                        st_d  = ST_TRAP;
                        pc_d  = TRAP_VEC;
                        epc_d = pc;
                    end else begin
                        pc_d      = redir.req ? redir.target : pc_next;
                        retire_ok = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                trap = 1'b1;
                // pc stays at TRAP_VEC, so the first handler fetch is TRAP_VEC itself.
                if (trap_clr) st_d = ST_RUN;
            end
            default: begin
                // Encoding 11 should never be reached; recover through BOOT.
                st_d = ST_BOOT;
            end
        endcase
    end

    // State, pc and exception-pc registers. Reset acts at once, without a clock edge.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            st_q     <= ST_BOOT;
            pc       <= RESET_VEC;
            trap_epc <= '0;
        end else begin
            st_q     <= st_d;
            pc       <= pc_d;
            trap_epc <= epc_d;
        end
    end

`ifdef PC_SEQ_RETIRE_CNT_EN
    // Retired-fetch counter: RUN cycles that are not stalled and do not trap.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)          retire_cnt <= '0;
        else if (retire_ok) retire_cnt <= retire_cnt + 32'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire_ok;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Testbench for pc_seq (XLEN=32, RESET_VEC=0, TRAP_VEC=0x100, INC=4,
// ALIGN_BITS=2). It applies a table of directed vectors, then a directed
// asynchronous reset and retire sequence, then random stimulus checked
// against a reference model.
module tb_pc_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, br_taken, jmp, trap_clr;
    logic [31:0] br_offset, jmp_target;
    logic [31:0] pc, pc_next, trap_epc;
    logic        pc_valid, trap;
    logic [1:0]  state;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pc_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_offset  (br_offset),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .trap_clr   (trap_clr),
        .pc         (pc),
        .pc_next    (pc_next),
        .pc_valid   (pc_valid),
        .trap       (trap),
        .trap_epc   (trap_epc),
        .state      (state)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Check every architectural output against one expected snapshot.
    // pc_valid and trap are implied by the mode: valid in RUN, trap in TRAP.
    task automatic chk_all(input string tag, input logic [31:0] e_pc,
                           input logic [1:0] e_st, input logic [31:0] e_epc);
        chk({tag, ".pc"},       pc,               e_pc);
        chk({tag, ".pc_next"},  pc_next,          e_pc + 32'd4);
        chk({tag, ".state"},    {30'd0, state},   {30'd0, e_st});
        chk({tag, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, (e_st == 2'b01)});
        chk({tag, ".trap"},     {31'd0, trap},     {31'd0, (e_st == 2'b10)});
        chk({tag, ".trap_epc"}, trap_epc,         e_epc);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        stall = 0; br_taken = 0; br_offset = 0; jmp = 0; jmp_target = 0; trap_clr = 0;
    endtask

    // Reference model: mode 0 BOOT, 1 RUN, 2 TRAP.
    logic [31:0] m_pc, m_epc, m_cnt;
    int          m_mode;

    task automatic model_step(input logic s, input logic b, input logic [31:0] off,
                              input logic j, input logic [31:0] tgt, input logic c);
        logic [31:0] dest;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!s) begin
                dest = j ? tgt : m_pc + off;
                if ((j || b) && (dest % 4 != 0)) begin
                    m_epc  = m_pc;
                    m_pc   = 32'h100;
                    m_mode = 2;
                end else begin
                    m_pc  = (j || b) ? dest : m_pc + 4;
                    m_cnt = m_cnt + 1;
                end
            end
        end else if (c) begin
            m_mode = 1;
        end
    endtask

    typedef struct {
        logic        s, b;
        logic [31:0] off;
        logic        j;
        logic [31:0] tgt;
        logic        c;
        logic [31:0] e_pc;
        logic [1:0]  e_st;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vt[19];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] off,
                                input logic j, input logic [31:0] tgt, input logic c,
                                input logic [31:0] e_pc, input logic [1:0] e_st,
                                input logic [31:0] e_epc);
        vec_t v;
        v.s = s; v.b = b; v.off = off; v.j = j; v.tgt = tgt; v.c = c;
        v.e_pc = e_pc; v.e_st = e_st; v.e_epc = e_epc;
        return v;
    endfunction

    initial begin
        //          s  b  off           j  tgt     c   pc            st     epc
        vt[0]  = mk(0, 0, 0,            0, 0,      0,  32'h0,        2'b01, 0);     // BOOT->RUN, pc holds
        vt[1]  = mk(0, 0, 0,            0, 0,      0,  32'h4,        2'b01, 0);
        vt[2]  = mk(0, 0, 0,            0, 0,      0,  32'h8,        2'b01, 0);
        vt[3]  = mk(0, 0, 0,            0, 0,      0,  32'hC,        2'b01, 0);
        vt[4]  = mk(0, 0, 0,            0, 0,      0,  32'h10,       2'b01, 0);
        vt[5]  = mk(1, 1, 8,            1, 32'h40, 0,  32'h10,       2'b01, 0);     // stall beats all
        vt[6]  = mk(1, 0, 0,            0, 0,      0,  32'h10,       2'b01, 0);
        vt[7]  = mk(1, 0, 0,            0, 0,      0,  32'h10,       2'b01, 0);
        vt[8]  = mk(0, 1, 8,            1, 32'h40, 0,  32'h40,       2'b01, 0);     // jmp beats branch
        vt[9]  = mk(0, 1, -32'sh44,     0, 0,      0,  32'hFFFF_FFFC, 2'b01, 0);    // negative branch wraps
        vt[10] = mk(0, 0, 0,            0, 0,      0,  32'h0,        2'b01, 0);     // sequential wrap
        vt[11] = mk(0, 0, 0,            1, 32'h20, 0,  32'h20,       2'b01, 0);
        vt[12] = mk(0, 0, 0,            1, 32'h33, 0,  32'h100,      2'b10, 32'h20); // misaligned jump
        vt[13] = mk(0, 0, 0,            1, 32'h33, 0,  32'h100,      2'b10, 32'h20);
        vt[14] = mk(1, 1, 4,            1, 32'h33, 0,  32'h100,      2'b10, 32'h20);
        vt[15] = mk(0, 0, 0,            0, 0,      1,  32'h100,      2'b01, 32'h20); // leave TRAP
        vt[16] = mk(0, 0, 0,            0, 0,      1,  32'h104,      2'b01, 32'h20); // clr ignored in RUN
        vt[17] = mk(0, 1, 2,            0, 0,      0,  32'h100,      2'b10, 32'h104); // misaligned branch
        vt[18] = mk(0, 0, 0,            0, 0,      1,  32'h100,      2'b01, 32'h104);

        idle_in();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all("reset", 32'h0, 2'b00, 32'h0);
`ifdef PC_SEQ_RETIRE_CNT_EN
        chk("reset.retire_cnt", retire_cnt, 32'd0);
`endif
        rst_n = 1'b0;
        chk_all("boot", 32'h0, 2'b00, 32'h0);

        foreach (vt[i]) begin
            stall = vt[i].s; br_taken = vt[i].b; br_offset = vt[i].off;
            jmp = vt[i].j; jmp_target = vt[i].tgt; trap_clr = vt[i].c;
            tick();
            chk_all($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_st, vt[i].e_epc);
        end

        // Enter TRAP, then assert reset between clock edges.
        idle_in();
        jmp = 1; jmp_target = 32'h33;
        tick();
        chk_all("pre_async", 32'h100, 2'b10, 32'h100);
        idle_in();
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 chk_all("async_rst", 32'h0, 2'b00, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        chk_all("boot2", 32'h0, 2'b00, 32'h0);
        tick();
        chk_all("run2", 32'h0, 2'b01, 32'h0);

        // 10 sequential cycles, 2 stalls and 1 trapping jump.
        repeat (10) tick();
        stall = 1;
        repeat (2) tick();
        chk_all("seq10", 32'h28, 2'b01, 32'h0);
        stall = 0; jmp = 1; jmp_target = 32'h33;
        tick();
        chk_all("trap2", 32'h100, 2'b10, 32'h28);
`ifdef PC_SEQ_RETIRE_CNT_EN
        chk("retire10", retire_cnt, 32'd10);
`endif
        idle_in();
        trap_clr = 1;
        tick();
        chk_all("clr2", 32'h100, 2'b01, 32'h28);

        // Random phase; the model starts from the known point reached above.
        m_pc = 32'h100; m_mode = 1; m_epc = 32'h28; m_cnt = 32'd10;
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] o, t;
            o = $urandom; t = $urandom;
            if ($urandom_range(3) != 0) o[1:0] = 2'b00;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            stall      = ($urandom_range(4) == 0);
            br_taken   = ($urandom_range(5) == 0);
            jmp        = ($urandom_range(7) == 0);
            br_offset  = o;
            jmp_target = t;
            trap_clr   = ($urandom_range(3) == 0);
            tick();
            model_step(stall, br_taken, br_offset, jmp, jmp_target, trap_clr);
            chk_all($sformatf("rnd%0d", k), m_pc, m_mode[1:0], m_epc);
`ifdef PC_SEQ_RETIRE_CNT_EN
            chk($sformatf("rnd%0d.retire_cnt", k), retire_cnt, m_cnt);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
Parametrised program-counter sequencer that replaces the fixed increment-only PC/adder pair in the fetch stage.
- Adds stall, relative branch, absolute jump, a boot cycle, and a misaligned-target trap state machine.
- Outputs the current fetch address and its increment to instruction memory and to the hex display drivers.

Parameters:
XLEN, 32, address width in bits
RESET_VEC, 0, PC value loaded by reset
TRAP_VEC, 32'h0000_0100, PC value loaded on misaligned-target trap
INC, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero (0 disables alignment check)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1)
stall  input  1  hold PC this cycle
br_taken  input  1  relative branch request
br_offset  input  XLEN  signed byte offset added to current pc
jmp  input  1  absolute jump request
jmp_target  input  XLEN  absolute jump address
trap_clr  input  1  leave TRAP state
pc  output  XLEN  current fetch address (register)
pc_next  output  XLEN  pc + INC, combinational, modulo 2^XLEN
pc_valid  output  1  pc is a legal fetch address this cycle
trap  output  1  high while in TRAP
trap_epc  output  XLEN  pc of the instruction that caused the last trap
state  output  2  00 BOOT, 01 RUN, 10 TRAP

Behaviour:
Reset (async, rst_n=1):
- pc=RESET_VEC, pc_valid=0, trap=0, trap_epc=0, state=BOOT.
- Asserting reset mid-operation overrides everything immediately.

BOOT:
- Lasts exactly one clock after reset release.
- pc holds RESET_VEC; all requests are ignored.
- Next state is RUN.

RUN:
- pc_valid=1.
- Priority per cycle: stall > jmp > br_taken > sequential.
- stall=1: pc holds. jmp and br_taken are ignored, so the requester must keep them asserted.
- jmp=1: target = jmp_target.
- br_taken=1 (no jmp): target = pc + br_offset, XLEN-bit two's-complement, wraps modulo 2^XLEN.
- Sequential: pc <= pc_next. Wraps from 2^XLEN-INC to 0 with no flag.
- Misaligned target (jmp or branch with target[ALIGN_BITS-1:0] != 0):
  - Next cycle: pc=TRAP_VEC, trap_epc=old pc, trap=1, pc_valid=0, state=TRAP.
  - The misaligned target is never loaded into pc.
- Sequential increments are never checked.
- trap_clr is ignored in RUN.

TRAP:
- pc holds TRAP_VEC; stall, jmp and br_taken are ignored.
- trap_clr=1 gives, next cycle: state=RUN, trap=0, pc_valid=1, pc stays TRAP_VEC (first handler fetch).
- trap_epc holds until the next trap or reset.

Latency and decode:
- All register updates take one clock.
- pc_next follows pc combinationally with zero latency.
- state encoding 11 is unreachable; if entered, next state is BOOT.

Optional Feature:
Macro PC_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (32 bits).
  - Reset value 0.
  - Increments on every RUN cycle with stall=0 that does not trap.
  - Wraps at 2^32.
- Not defined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset, then release; no requests for 4 cycles -> state BOOT for 1 cycle, then pc = 0, 0, 4, 8, 12; pc_valid rises together with entry to RUN; pc_next = pc+4.
- At pc=0x10: stall for 3 cycles, then jmp=1 with jmp_target=0x40 and br_taken=1 with br_offset=8 in the same cycle -> pc holds 0x10 for 3 cycles, then becomes 0x40 (jmp wins).
- At pc=0x40: br_taken=1, br_offset=-0x44 -> pc=0xFFFF_FFFC, then sequential increment to 0x0000_0000 (wrap).
- At pc=0x20: jmp_target=0x33 -> next cycle state TRAP, pc=0x100, trap_epc=0x20, trap=1, pc_valid=0. jmp held 2 more cycles -> no change. trap_clr=1 -> RUN, pc=0x100, then 0x104.
- Assert rst_n mid-TRAP, asynchronously between clock edges -> pc=0, trap=0, trap_epc=0, state=BOOT immediately, without waiting for a clock edge.
- With PC_SEQ_RETIRE_CNT_EN defined: 10 sequential cycles, 2 stall cycles and 1 trapping jump -> retire_cnt=10.
